// File: rtl/mips_pkg.sv
// Shared types and default widths for the unified memory-port arbiter.
package mips_pkg;

  localparam int ARB_ADDR_W     = 32;
  localparam int ARB_DATA_W     = 32;
  localparam int ARB_MAX_D_WINS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between fetch (I) and data (D).
// Optional starvation guard for I is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int MAX_D_WINS = ARB_MAX_D_WINS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_kill,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MAX_D_WINS < 1) begin : g_bad_max_d_wins
    $error("MAX_D_WINS must be at least 1");
  end

  arb_state_e        state_q;
  logic              killed_q;
  logic              mem_req_q, mem_we_q, i_done_q, d_done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;

  logic i_wait, grant_i, grant_d;

  assign i_wait = i_req & ~i_kill;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_D_WINS + 1);
  logic [CNT_W-1:0] d_wins_q;
  logic             starve;

  assign starve  = (d_wins_q == CNT_W'(MAX_D_WINS));
  assign grant_i = i_wait & (~d_req | starve);

  // Counts back-to-back D wins over a waiting I; saturates at MAX_D_WINS.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_wins_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant_i) begin
        d_wins_q <= '0;
      end else if (grant_d) begin
        if (!i_wait)
          d_wins_q <= '0;
        else if (!starve)
          d_wins_q <= d_wins_q + 1'b1;
      end
    end
  end
`else
  assign grant_i = i_wait & ~d_req;
`endif

  assign grant_d = d_req & ~grant_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      killed_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end else if (grant_i) begin
            state_q    <= BUSY_I;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= i_addr;
          end
        end
        BUSY_I: begin
          if (i_kill)
            killed_q <= 1'b1;
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
            // A kill arriving with the ack still discards the fetch.
            if (!(killed_q || i_kill)) begin
              i_rdata_q <= mem_rdata;
              i_done_q  <= 1'b1;
            end
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= RESP;
            d_done_q  <= 1'b1;
            if (!mem_we_q)
              d_rdata_q <= mem_rdata;
          end
        end
        RESP: begin
          i_done_q <= 1'b0;
          d_done_q <= 1'b0;
          killed_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_done    = i_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, memory model, done monitor.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_kill, i_done;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_done;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_WINS(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            src_d;
    logic [DW-1:0] rdata;
  } rsp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] rdata;
  } mem_t;

  rsp_t sbq[$];
  mem_t mq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Done monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    rsp_t e;
    if (i_done || d_done) begin
      chk("one_done_only", {63'd0, i_done & d_done}, 64'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("done_src", {63'd0, d_done}, {63'd0, e.src_d});
        chk("done_rdata", d_done ? d_rdata : i_rdata, e.rdata);
      end
    end
  end

  // Memory model: checks request fields every cycle, acks after the entry's wait count.
  int wcnt = 0;
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (!mem_req) begin
      wcnt = 0;
    end else if (mq.size() == 0) begin
      chk("mem_unexpected_req", 64'd1, 64'd0);
    end else begin
      chk("mem_we", {63'd0, mem_we}, {63'd0, mq[0].we});
      chk("mem_addr", mem_addr, mq[0].addr);
      if (mq[0].we) chk("mem_wdata", mem_wdata, mq[0].wdata);
      if (wcnt >= mq[0].waits) begin
        mem_ack   = 1'b1;
        mem_rdata = mq[0].rdata;
        mq.delete(0);
      end else begin
        wcnt++;
        mem_rdata = $urandom;
      end
    end
  end

  task automatic drive_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bit seen = 0;
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (d_done) seen = 1;
    end
    d_req = 1'b0;
    if (!seen) chk("d_timeout", 64'd1, 64'd0);
  endtask

  task automatic drive_i(input logic [AW-1:0] a);
    bit seen = 0;
    i_addr = a; i_req = 1'b1;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (i_done) seen = 1;
    end
    i_req = 1'b0;
    if (!seen) chk("i_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_mem_req(input logic lvl);
    bit seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (mem_req == lvl) seen = 1;
    end
    if (!seen) chk("mem_req_wait_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    i_req = 0; i_kill = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_done", {62'd0, i_done, d_done}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // I-only zero-wait fetch with exact latency.
    mq.push_back('{1'b0, 32'h40, 32'h0, 0, 32'h2008_0005});
    sbq.push_back('{1'b0, 32'h2008_0005});
    i_addr = 32'h40; i_req = 1'b1;
    @(negedge clk);
    chk("t1_mem_req_c1", {63'd0, mem_req}, 64'd1);
    chk("t1_mem_addr_c1", mem_addr, 32'h40);
    @(negedge clk);
    chk("t1_i_done_c2", {63'd0, i_done}, 64'd1);
    i_req = 1'b0;
    @(negedge clk);
    chk("t1_i_done_c3", {63'd0, i_done}, 64'd0);
    chk("t1_i_rdata", i_rdata, 32'h2008_0005);

    // Simultaneous D load and I fetch: D first.
    mq.push_back('{1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF});
    mq.push_back('{1'b0, 32'h44, 32'h0, 0, 32'h0000_0001});
    sbq.push_back('{1'b1, 32'hDEAD_BEEF});
    sbq.push_back('{1'b0, 32'h0000_0001});
    fork
      drive_d(1'b0, 32'h100, 32'h0);
      drive_i(32'h44);
    join
    @(negedge clk);

    // Store leaves d_rdata untouched.
    mq.push_back('{1'b1, 32'h200, 32'h1234_5678, 1, 32'hFFFF_FFFF});
    sbq.push_back('{1'b1, 32'hDEAD_BEEF});
    drive_d(1'b1, 32'h200, 32'h1234_5678);
    @(negedge clk);
    chk("store_d_rdata", d_rdata, 32'hDEAD_BEEF);

    // Kill a fetch in flight, then a fresh fetch.
    mq.push_back('{1'b0, 32'h60, 32'h0, 2, 32'hBAD0_BAD0});
    i_addr = 32'h60; i_req = 1'b1;
    wait_mem_req(1'b1);
    i_kill = 1'b1; i_req = 1'b0;
    @(negedge clk);
    i_kill = 1'b0;
    wait_mem_req(1'b0);
    repeat (2) @(negedge clk);
    chk("kill_i_rdata", i_rdata, 32'h0000_0001);
    mq.push_back('{1'b0, 32'h80, 32'h0, 0, 32'h8C42_0000});
    sbq.push_back('{1'b0, 32'h8C42_0000});
    drive_i(32'h80);
    @(negedge clk);
    chk("post_kill_i_rdata", i_rdata, 32'h8C42_0000);

    // Reset during BUSY_D.
    mq.push_back('{1'b0, 32'h300, 32'h0, 10, 32'h5555_AAAA});
    d_we = 1'b0; d_addr = 32'h300; d_req = 1'b1;
    wait_mem_req(1'b1);
    @(negedge clk);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("rstmid_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rstmid_d_done", {63'd0, d_done}, 64'd0);
    chk("rstmid_mem_addr", mem_addr, 64'd0);
    rst = 1'b0;
    mq.delete(0);
    repeat (4) @(negedge clk);
    chk("rstmid_idle_mem_req", {63'd0, mem_req}, 64'd0);

    // Both requesters held: grant pattern depends on the starvation guard.
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 7; k++) begin
      if (k == 4) begin
        mq.push_back('{1'b0, 32'h500, 32'h0, 0, 32'h22});
        sbq.push_back('{1'b0, 32'h22});
      end else begin
        mq.push_back('{1'b0, 32'h400, 32'h0, 0, 32'h11});
        sbq.push_back('{1'b1, 32'h11});
      end
    end
`else
    for (int k = 0; k < 7; k++) begin
      mq.push_back('{1'b0, 32'h400, 32'h0, 0, 32'h11});
      sbq.push_back('{1'b1, 32'h11});
    end
`endif
    d_we = 1'b0; d_addr = 32'h400; i_addr = 32'h500;
    d_req = 1'b1; i_req = 1'b1;
    dones = 0;
    for (int n = 0; n < 100 && dones < 7; n++) begin
      @(negedge clk);
      if (i_done || d_done) dones++;
    end
    d_req = 1'b0; i_req = 1'b0;
    chk("starve_done_count", dones, 7);
    repeat (4) @(negedge clk);

    chk("sb_empty", sbq.size(), 0);
    chk("mem_q_empty", mq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one unified, variable-latency memory port between the pipeline's instruction-fetch requester (I, read-only) and data requester (D, load/store).
- Sits between the pipeline and the single memory bus.
- Per-requester done pulses let the hazard unit derive stallF and stallM.
- D has fixed priority over I, because D belongs to the older instruction.
- A fetch in flight can be killed on a branch or jump redirect.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
MAX_D_WINS, 4, consecutive D grants allowed while I waits (used only with the optional feature)

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held with a stable i_addr until i_done or i_kill
i_addr  in  ADDR_W  fetch address
i_kill  in  1  discard the fetch currently pending or in flight (redirect)
i_done  out  1  one-cycle pulse; i_rdata valid in this cycle
i_rdata  out  DATA_W  registered fetch data
d_req  in  1  data request; held with stable d_we, d_addr, d_wdata until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_done  out  1  one-cycle pulse; d_rdata valid for loads
d_rdata  out  DATA_W  registered load data
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  write enable toward memory
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_ack  in  1  one-cycle completion from memory; mem_rdata valid in the same cycle
mem_rdata  in  DATA_W  memory read data

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP. All outputs are registered.
- Reset values: state = IDLE; mem_req, mem_we, i_done, d_done = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0.
- Reset mid-transaction: mem_req drops the next cycle and no done pulse is issued. The memory tolerates an abandoned request.
- IDLE:
  - If d_req = 1, latch the D fields and go to BUSY_D.
  - Else if i_req = 1 and i_kill = 0, latch i_addr and go to BUSY_I.
  - mem_req rises in the first BUSY cycle.
- BUSY_x:
  - mem_req = 1, with address and data stable.
  - On mem_ack: capture mem_rdata into x_rdata (I, or D when d_we = 0), deassert mem_req, go to RESP.
  - Stores leave d_rdata unchanged.
- RESP:
  - Pulse x_done for exactly one cycle, then go to IDLE.
  - Requests are not sampled in RESP, so a requester dropping req after done is never double-granted.
- Minimum latency, zero-wait memory: req sampled at cycle 0, mem_req and mem_ack at cycle 1, done at cycle 2, next grant sampled at cycle 3.
- i_kill:
  - In IDLE it suppresses the I grant.
  - In BUSY_I it sets a killed flag. The transaction still completes on the memory, but RESP emits no i_done and i_rdata is not updated.
  - The flag clears on leaving RESP.
  - A new i_req with a new address is served from the next IDLE.
- mem_ack outside BUSY_x is ignored.
- i_done and d_done are never high in the same cycle.
- Exactly one outstanding memory transaction at any time.

Optional Feature:
MEM_ARB_STARVE_GUARD_EN.
- Defined: a saturating counter counts consecutive D grants made while i_req = 1 and i_kill = 0.
  - When the counter reaches MAX_D_WINS, the next IDLE arbitration with both requesting grants I.
  - The counter clears on any I grant, or on any D grant made while I is not waiting.
- Undefined: pure D priority, and no counter logic exists.

Decomposition:
- mips_pkg holds:
  - the arb_state_e enum (IDLE, BUSY_I, BUSY_D, RESP);
  - the arb_src_e enum (SRC_I, SRC_D);
  - the localparam default widths.
- No sub-module: the single FSM with its capture registers is the natural unit. The starvation counter stays inline under the macro.

Test Plan:
- I-only read, zero-wait: i_req = 1, i_addr = 0x0000_0040, mem_ack in the first BUSY cycle with mem_rdata = 0x2008_0005 -> mem_addr = 0x40 at cycle 1, i_done pulse at cycle 2, i_rdata = 0x2008_0005.
- Simultaneous i_req and d_req (load 0x100, 3 wait cycles, rdata 0xDEAD_BEEF) -> D served first, d_done with d_rdata = 0xDEAD_BEEF; I granted in the following IDLE; never both done pulses together.
- Store: d_we = 1, d_addr = 0x200, d_wdata = 0x1234_5678 -> mem_we = 1 and mem_wdata = 0x1234_5678 held until ack; d_done pulses; d_rdata unchanged.
- Kill in flight: i_kill pulsed during BUSY_I with 2 wait cycles -> no i_done, i_rdata unchanged; the next i_req to 0x80 completes normally.
- Reset mid-BUSY_D: rst asserted with mem_req = 1 -> mem_req = 0 the next cycle, state IDLE, no d_done.
- With MEM_ARB_STARVE_GUARD_EN and MAX_D_WINS = 4: d_req and i_req held continuously -> exactly 4 D grants, then 1 I grant, then D again. Without the macro -> I is never granted.
